// File: rtl/trig_log_pkg.sv
// Shared types and helpers for the trigger event logger.
// A record is packed as {src, timestamp}.
package trig_log_pkg;

    localparam int TRIG_CNT_W = 16;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_EV   = 2'b01,
        SRC_SIG  = 2'b10,
        SRC_BOTH = 2'b11
    } src_e;

    function automatic int rec_w(input int cnt_w);
        return cnt_w + 2;
    endfunction

    // Bit 1 marks a sig rising edge and bit 0 an ev strobe.
    function automatic src_e make_src(input logic sig_edge, input logic ev);
        return src_e'({sig_edge, ev});
    endfunction

endpackage

// File: rtl/trig_log_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// A push is accepted while full if a pop happens on the same edge.
module trig_log_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en;
    logic             pop_en;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);
    assign rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; cleared pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/trig_event_logger.sv
// Captures sig rising edges and ev strobes as timestamped records,
// drains them over valid/ready, and tracks trigger count, done and overflow.
module trig_event_logger
    import trig_log_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int DEPTH  = 4,
    parameter int EXPECT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sig,
    input  logic                  ev,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W+1:0]      out_data,
    output logic [TRIG_CNT_W-1:0] trig_cnt,
    output logic                  done,
    output logic                  overflow
);

    localparam int                  REC_W      = rec_w(CNT_W);
    localparam logic [TRIG_CNT_W-1:0] EXPECT_CNT = TRIG_CNT_W'(EXPECT);

    logic [CNT_W-1:0]      cyc_q, cyc_d;
    logic                  sig_q;
    logic [TRIG_CNT_W-1:0] trig_cnt_q, trig_cnt_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;

    logic                  sig_edge;
    logic                  trig;
    src_e                  src;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [REC_W-1:0]      fifo_rdata;

    assign pop       = out_valid & out_ready;
    assign out_valid = ~fifo_empty;
    assign out_data  = out_valid ? fifo_rdata : '0;
    assign trig_cnt  = trig_cnt_q;
    assign done      = done_q;
    assign overflow  = ovf_q;

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sig_edge   = sig & ~sig_q;
        trig       = sig_edge | ev;
        src        = make_src(sig_edge, ev);
        cyc_d      = cyc_q + CNT_W'(1);
        trig_cnt_d = trig_cnt_q;
        if (trig && (trig_cnt_q != '1)) trig_cnt_d = trig_cnt_q + TRIG_CNT_W'(1);
        // A drop happens only when full and the head is not leaving this cycle.
        ovf_d      = ovf_q | (trig & fifo_full & ~pop);
        done_d     = done_q | (trig_cnt_d >= EXPECT_CNT);
    end

    // NOTE: state registers use non-blocking assignments so all update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q      <= '0;
            sig_q      <= 1'b0;
            trig_cnt_q <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            cyc_q      <= cyc_d;
            sig_q      <= sig;
            trig_cnt_q <= trig_cnt_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    trig_log_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (trig),
        .wdata ({src, cyc_q}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_trig_event_logger.sv
// Directed and random stimulus against a queue-based reference model;
// a narrow-counter instance shares the inputs to exercise timestamp wrap.
module tb_trig_event_logger;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig;
    logic        ev;
    logic        out_ready;

    logic        a_valid;
    logic [33:0] a_data;
    logic [15:0] a_cnt;
    logic        a_done;
    logic        a_ovf;

    logic        b_valid;
    logic [5:0]  b_data;
    logic [15:0] b_cnt;
    logic        b_done;
    logic        b_ovf;

    trig_event_logger #(.CNT_W(32), .DEPTH(DEPTH), .EXPECT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig       (sig),
        .ev        (ev),
        .out_valid (a_valid),
        .out_ready (out_ready),
        .out_data  (a_data),
        .trig_cnt  (a_cnt),
        .done      (a_done),
        .overflow  (a_ovf)
    );

    trig_event_logger #(.CNT_W(4), .DEPTH(DEPTH), .EXPECT(2)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .sig       (sig),
        .ev        (ev),
        .out_valid (b_valid),
        .out_ready (out_ready),
        .out_data  (b_data),
        .trig_cnt  (b_cnt),
        .done      (b_done),
        .overflow  (b_ovf)
    );

    always #5 clk = ~clk;

    // Reference model: records are {src, 32-bit timestamp}.
    logic [33:0] m_q[$];
    logic [31:0] m_cyc  = '0;
    int          m_tc   = 0;
    bit          m_done = 1'b0;
    bit          m_ovf  = 1'b0;
    bit          m_sigq = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [33:0] exp_a;
        logic [5:0]  exp_b;
        exp_a = '0;
        exp_b = '0;
        if (m_q.size() != 0) begin
            exp_a = m_q[0];
            exp_b = {m_q[0][33:32], m_q[0][3:0]};
        end
        check("out_valid", a_valid, m_q.size() != 0);
        check("out_data", a_data, exp_a);
        check("trig_cnt", a_cnt, m_tc);
        check("done", a_done, m_done);
        check("overflow", a_ovf, m_ovf);
        check("w_out_valid", b_valid, m_q.size() != 0);
        check("w_out_data", b_data, exp_b);
    endtask

    task automatic model_step();
        bit edge_s;
        bit trig;
        if (rst) begin
            m_q.delete();
            m_cyc  = '0;
            m_tc   = 0;
            m_done = 1'b0;
            m_ovf  = 1'b0;
            m_sigq = 1'b0;
        end else begin
            edge_s = sig && !m_sigq;
            trig   = edge_s || ev;
            if (out_ready && m_q.size() != 0) void'(m_q.pop_front());
            if (trig) begin
                if (m_q.size() < DEPTH) m_q.push_back({edge_s, ev, m_cyc});
                else m_ovf = 1'b1;
                if (m_tc < 65535) m_tc++;
            end
            if (m_tc >= 2) m_done = 1'b1;
            m_sigq = sig;
            m_cyc  = m_cyc + 32'd1;
        end
    endtask

    task automatic tick();
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_to(input int n);
        for (int k = 0; k < 64 && m_cyc != 32'(n); k++) tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        ev  = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sig = 1'b0; ev = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick();
        rst = 1'b0;

        // Basic: ev at cycle 2, sig edge at cycle 4.
        run_to(2);
        ev = 1'b1; tick(); ev = 1'b0;
        check("basic_rec1", a_data, {2'b01, 32'd2});
        run_to(4);
        sig = 1'b1; tick();
        check("basic_rec2", a_data, {2'b10, 32'd4});
        check("basic_cnt", a_cnt, 16'd2);
        check("basic_done", a_done, 1'b1);
        check("basic_ovf", a_ovf, 1'b0);

        // Level held high, then falling edge: no new records.
        repeat (10) tick();
        sig = 1'b0;
        repeat (3) tick();
        check("level_cnt", a_cnt, 16'd2);
        check("level_empty", a_valid, 1'b0);

        // Simultaneous edge and ev.
        do_reset(2);
        run_to(7);
        sig = 1'b1; ev = 1'b1; tick(); ev = 1'b0;
        check("sim_rec", a_data, {2'b11, 32'd7});
        check("sim_cnt", a_cnt, 16'd1);
        sig = 1'b0; tick();

        // sig high through reset release counts as an edge at timestamp 0.
        sig = 1'b1;
        do_reset(2);
        tick();
        check("rst_sig_rec", a_data, {2'b10, 32'd0});
        sig = 1'b0;
        repeat (2) tick();

        // Backpressure and overflow.
        out_ready = 1'b0;
        do_reset(2);
        tick();
        ev = 1'b1; repeat (5) tick(); ev = 1'b0;
        check("ovf_flag", a_ovf, 1'b1);
        check("ovf_cnt", a_cnt, 16'd5);
        repeat (3) tick();
        check("stall_data", a_data, {2'b01, 32'd1});
        out_ready = 1'b1;
        repeat (5) tick();

        // Full plus pop: accepted, no overflow.
        out_ready = 1'b0;
        do_reset(2);
        ev = 1'b1; repeat (4) tick();
        out_ready = 1'b1; tick();
        ev = 1'b0; out_ready = 1'b0;
        check("fullpop_ovf", a_ovf, 1'b0);
        check("fullpop_head", a_data, {2'b01, 32'd1});
        out_ready = 1'b1;
        repeat (5) tick();

        // Reset with records queued.
        out_ready = 1'b0;
        do_reset(2);
        ev = 1'b1; repeat (3) tick(); ev = 1'b0;
        tick();
        check("mid_done_pre", a_done, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_valid", a_valid, 1'b0);
        check("mid_cnt", a_cnt, 16'd0);
        check("mid_done", a_done, 1'b0);
        out_ready = 1'b1;

        // Timestamp wrap on the 4-bit counter instance.
        do_reset(2);
        run_to(17);
        ev = 1'b1; tick(); ev = 1'b0;
        check("wrap_ts", b_data, {2'b01, 4'd1});
        check("wide_ts", a_data, {2'b01, 32'd17});
        tick();

        // Random traffic.
        repeat (400) begin
            sig       = 1'($urandom_range(0, 1));
            ev        = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; ev = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
